// File: rtl/conv_s2_pkg.sv
// Shared geometry, beat sideband and FSM encoding for the stride-2 window reader.
package conv_s2_pkg;

    localparam int IMG_DIM  = 9;
    localparam int K_DIM    = 3;
    localparam int STRIDE   = 2;
    localparam int CH1_BASE = 81;
    localparam int OUT_DIM  = (IMG_DIM - K_DIM) / STRIDE + 1;
    localparam int TAPS     = K_DIM * K_DIM;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [1:0] orow;
        logic [1:0] ocol;
    } beat_sb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/conv_s2_window_reader_skid_fifo.sv
// Two-entry register FIFO carrying both channel taps plus the beat sideband.
module conv_s2_skid_fifo
    import conv_s2_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_d0_i,
    input  logic [DATA_W-1:0] push_d1_i,
    input  beat_sb_t          push_sb_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_d0_o,
    output logic [DATA_W-1:0] head_d1_o,
    output beat_sb_t          head_sb_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] d0_q [2];
    logic [DATA_W-1:0] d1_q [2];
    beat_sb_t          sb_q [2];
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    // Occupancy: a push and a pop in the same cycle leave the count unchanged.
    always_comb begin
        count_d = count_q + 2'(push_i) - 2'(pop_i);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                d0_q[i] <= '0;
                d1_q[i] <= '0;
                sb_q[i] <= '0;
            end
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                d0_q[wr_q] <= push_d0_i;
                d1_q[wr_q] <= push_d1_i;
                sb_q[wr_q] <= push_sb_i;
                wr_q       <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

    assign head_d0_o = d0_q[rd_q];
    assign head_d1_o = d1_q[rd_q];
    assign head_sb_o = sb_q[rd_q];
    assign count_o   = count_q;

endmodule

// File: rtl/conv_s2_window_reader.sv
// Walks every 3x3 stride-2 window of a 9x9 two-channel map and streams tap pairs.
module conv_s2_window_reader
    import conv_s2_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doa,
    input  logic [DATA_W-1:0] ram_dob,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data0,
    output logic [DATA_W-1:0] m_data1,
    output logic              m_first,
    output logic              m_last,
    output logic [1:0]        m_orow,
    output logic [1:0]        m_ocol
);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_DIM - K_DIM + 1);
    localparam logic [ADDR_W-1:0] WIN_STEP  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] OROW_STEP = ADDR_W'(STRIDE * IMG_DIM);
    localparam logic [ADDR_W-1:0] CH1_OFS   = ADDR_W'(CH1_BASE);
    localparam logic [1:0]        KMAX      = 2'(K_DIM - 1);
    localparam logic [1:0]        OMAX      = 2'(OUT_DIM - 1);

    state_e            state_q, state_d;
    logic [1:0]        orow_q, orow_d, ocol_q, ocol_d, kr_q, kr_d, kc_q, kc_d;
    logic [ADDR_W-1:0] addr_q, addr_d, win_q, win_d, row_q, row_d;
    logic              inflight_q;
    beat_sb_t          tag_q, tag_d;

    logic [1:0]        fifo_count_s;
    logic              pop_s;
    logic              issue_s;
    logic              last_tap_s;
    logic [2:0]        credit_s;
    beat_sb_t          head_sb_s;

    assign m_valid    = (fifo_count_s != 2'd0);
    assign pop_s      = m_valid && m_ready;
    // A slot freed by this cycle's pop may be reused immediately, keeping one beat per cycle.
    assign credit_s   = {1'b0, fifo_count_s} - {2'b00, pop_s} + {2'b00, inflight_q};
    assign issue_s    = (state_q == ST_RUN) && (credit_s < 3'd2);
    assign last_tap_s = (orow_q == OMAX) && (ocol_q == OMAX) && (kr_q == KMAX) && (kc_q == KMAX);

    // Next-state: FSM plus incremental scan counters and address generator.
    always_comb begin
        state_d = state_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        addr_d  = addr_q;
        win_d   = win_q;
        row_d   = row_q;
        tag_d   = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    orow_d  = 2'd0;
                    ocol_d  = 2'd0;
                    kr_d    = 2'd0;
                    kc_d    = 2'd0;
                    addr_d  = '0;
                    win_d   = '0;
                    row_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    tag_d.first = (kr_q == 2'd0) && (kc_q == 2'd0);
                    tag_d.last  = (kr_q == KMAX) && (kc_q == KMAX);
                    tag_d.orow  = orow_q;
                    tag_d.ocol  = ocol_q;
                    if (kc_q != KMAX) begin
                        kc_d   = kc_q + 2'd1;
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else if (kr_q != KMAX) begin
                        kc_d   = 2'd0;
                        kr_d   = kr_q + 2'd1;
                        addr_d = addr_q + ROW_STEP;
                    end else if (ocol_q != OMAX) begin
                        kc_d   = 2'd0;
                        kr_d   = 2'd0;
                        ocol_d = ocol_q + 2'd1;
                        win_d  = win_q + WIN_STEP;
                        addr_d = win_q + WIN_STEP;
                    end else begin
                        kc_d   = 2'd0;
                        kr_d   = 2'd0;
                        ocol_d = 2'd0;
                        orow_d = orow_q + 2'd1;
                        row_d  = row_q + OROW_STEP;
                        win_d  = row_q + OROW_STEP;
                        addr_d = row_q + OROW_STEP;
                    end
                    if (last_tap_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((fifo_count_s == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            orow_q     <= 2'd0;
            ocol_q     <= 2'd0;
            kr_q       <= 2'd0;
            kc_q       <= 2'd0;
            addr_q     <= '0;
            win_q      <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            addr_q     <= addr_d;
            win_q      <= win_d;
            row_q      <= row_d;
            inflight_q <= issue_s;
            tag_q      <= tag_d;
        end
    end

    conv_s2_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (inflight_q),
        .push_d0_i (ram_doa),
        .push_d1_i (ram_dob),
        .push_sb_i (tag_q),
        .pop_i     (pop_s),
        .head_d0_o (m_data0),
        .head_d1_o (m_data1),
        .head_sb_o (head_sb_s),
        .count_o   (fifo_count_s)
    );

    assign ram_en    = issue_s;
    assign ram_addra = addr_q;
    assign ram_addrb = addr_q + CH1_OFS;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DRAIN) && (fifo_count_s == 2'd0) && !inflight_q;
    assign m_first   = head_sb_s.first;
    assign m_last    = head_sb_s.last;
    assign m_orow    = head_sb_s.orow;
    assign m_ocol    = head_sb_s.ocol;

endmodule

// File: tb/tb_conv_s2_window_reader.sv
// Scoreboard bench for conv_s2_window_reader with a behavioural dual-port RAM.
module tb_conv_s2_window_reader;

    localparam int DW = 16;
    localparam int AW = 10;

    typedef struct packed {
        logic [15:0] d0;
        logic [15:0] d1;
        logic        first;
        logic        last;
        logic [1:0]  orow;
        logic [1:0]  ocol;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, ram_en, m_valid, m_first, m_last;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_doa = '0;
    logic [DW-1:0] ram_dob = '0;
    logic [DW-1:0] m_data0, m_data1;
    logic [1:0]    m_orow, m_ocol;
    logic          m_ready = 1'b0;

    logic [15:0] mem [0:1023];
    beat_t       exp_q [$];
    beat_t       got [0:143];
    beat_t       stall_beat;
    bit          stall_prev = 1'b0;
    bit          rand_en = 1'b0;
    bit          ready_force = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          issued = 0;
    int          done_cnt = 0;
    int          first_acc_cyc = 0;
    int          last_acc_cyc = 0;
    int          first_valid_cyc = -1;
    int          start_cyc = 0;

    int w00 [9] = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
    int w33 [9] = '{60, 61, 62, 69, 70, 71, 78, 79, 80};
    int pad33 [9] = '{16'hFFFF, 16'hFFFF, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0};

    conv_s2_window_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ram_en(ram_en), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
        .ram_doa(ram_doa), .ram_dob(ram_dob), .m_valid(m_valid), .m_ready(m_ready),
        .m_data0(m_data0), .m_data1(m_data1), .m_first(m_first), .m_last(m_last),
        .m_orow(m_orow), .m_ocol(m_ocol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ram_en) begin
            issued = issued + 1;
            ram_doa <= mem[ram_addra];
            ram_dob <= mem[ram_addrb];
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_force;
    end

    function automatic beat_t cur_beat();
        beat_t b;
        b.d0 = m_data0; b.d1 = m_data1; b.first = m_first; b.last = m_last;
        b.orow = m_orow; b.ocol = m_ocol;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops, stall stability, credit bound and done timing.
    always @(negedge clk) begin
        if (rst_n) begin
            beat_t c, e;
            c = cur_beat();
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (busy) begin
                checks = checks + 1;
                if (issued - acc_cnt > 2) begin
                    errors = errors + 1;
                    $display("FAIL outstanding: got %0d expected <=2", issued - acc_cnt);
                end
            end
            if (stall_prev) begin
                checks = checks + 1;
                if (!m_valid || c != stall_beat) begin
                    errors = errors + 1;
                    $display("FAIL stall_hold: got %h expected %h", c, stall_beat);
                end
            end
            stall_prev = m_valid && !m_ready;
            if (stall_prev) stall_beat = c;
            if (m_valid && m_ready) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL extra_beat: got %h expected none", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c != e) begin
                        errors = errors + 1;
                        $display("FAIL beat%0d: got %h expected %h", acc_cnt, c, e);
                    end
                end
                if (acc_cnt < 144) got[acc_cnt] = c;
                if (acc_cnt == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                acc_cnt = acc_cnt + 1;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                check("done_timing", 32'(cyc), 32'(last_acc_cyc + 1));
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic build_exp();
        beat_t b;
        exp_q.delete();
        for (int orow = 0; orow < 4; orow++)
            for (int ocol = 0; ocol < 4; ocol++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) begin
                        int a;
                        a = (orow * 2 + kr) * 9 + ocol * 2 + kc;
                        b.d0 = mem[a]; b.d1 = mem[a + 81];
                        b.first = (kr == 0 && kc == 0); b.last = (kr == 2 && kc == 2);
                        b.orow = 2'(orow); b.ocol = 2'(ocol);
                        exp_q.push_back(b);
                    end
    endtask

    task automatic frame_init();
        acc_cnt = 0; issued = 0; done_cnt = 0; first_valid_cyc = -1;
        build_exp();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1; start_cyc = cyc;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check({name, "_done_once"}, 32'(done_cnt), 32'd1);
        check({name, "_beats"}, 32'(acc_cnt), 32'd144);
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        check({tag, "_addra"}, 32'(ram_addra), 32'd0);
        check({tag, "_addrb"}, 32'(ram_addrb), 32'd81);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_first"}, 32'(m_first), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_m_orow"}, 32'(m_orow), 32'd0);
        check({tag, "_m_ocol"}, 32'(m_ocol), 32'd0);
        check({tag, "_m_data0"}, 32'(m_data0), 32'd0);
        check({tag, "_m_data1"}, 32'(m_data1), 32'd0);
    endtask

    task automatic check_windows(input string tag);
        for (int i = 0; i < 9; i++) begin
            check({tag, "_w00_d0"}, 32'(got[i].d0), 32'(w00[i]));
            check({tag, "_w00_d1"}, 32'(got[i].d1), 32'(w00[i] + 81));
            check({tag, "_w33_d0"}, 32'(got[135 + i].d0), 32'(w33[i]));
            check({tag, "_w33_d1"}, 32'(got[135 + i].d1), 32'(w33[i] + 81));
        end
        check({tag, "_w33_first"}, 32'(got[135].first), 32'd1);
        check({tag, "_w33_last"}, 32'(got[143].last), 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame, downstream always ready.
        rand_en = 1'b0; ready_force = 1'b1;
        frame_init(); pulse_start(); wait_done("ready1");
        check("ready1_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
        check("ready1_no_gaps", 32'(last_acc_cyc - first_acc_cyc), 32'd143);
        check_windows("ready1");

        // Random backpressure.
        rand_en = 1'b1;
        frame_init(); pulse_start(); wait_done("random");
        check_windows("random");
        rand_en = 1'b0;

        // Long stall on the first beat.
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        frame_init(); pulse_start();
        n = 0;
        while (!m_valid && n < 20) begin @(negedge clk); n++; end
        repeat (20) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data0", 32'(m_data0), 32'd0);
            @(negedge clk);
        end
        check("stall_ram_en", 32'(ram_en), 32'd0);
        check("stall_issued", 32'(issued), 32'd2);
        ready_force = 1'b1;
        wait_done("stall");
        check("stall_resume", 32'(got[1].d0), 32'd1);

        // Start while busy is ignored.
        frame_init(); pulse_start();
        n = 0;
        while (acc_cnt < 50 && n < 500) begin @(negedge clk); n++; end
        pulse_start();
        wait_done("restart");

        // Reset mid-frame, then a fresh frame.
        frame_init(); pulse_start();
        n = 0;
        while (acc_cnt < 70 && n < 500) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        check("midreset_no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        frame_init(); pulse_start(); wait_done("afterreset");
        check("afterreset_d0", 32'(got[0].d0), 32'd0);
        check("afterreset_first", 32'(got[0].first), 32'd1);
        check("afterreset_orow", 32'(got[0].orow), 32'd0);
        check("afterreset_ocol", 32'(got[0].ocol), 32'd0);

        // Pad-pattern preload.
        for (int i = 0; i < 162; i++)
            mem[i] = (((i % 81) % 9) == 8 || (i % 81) >= 72) ? 16'h0000 : 16'hFFFF;
        frame_init(); pulse_start(); wait_done("pad");
        for (int i = 0; i < 9; i++) begin
            check("pad_w33_d0", 32'(got[135 + i].d0), 32'(pad33[i]));
            check("pad_w33_d1", 32'(got[135 + i].d1), 32'(pad33[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
